// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: PC, in-order memory requests, and an instruction buffer
// with pre-split decode fields. Redirects flush the buffer and discard stale responses.
module instr_fetch_unit #(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic                     mem_req_valid,
    input  logic                     mem_req_ready,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    input  logic                     mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]    mem_rsp_data,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [DATA_WIDTH-1:0]    instr,
    output logic [ADDRESS_WIDTH-1:0] instr_pc,
    output logic [6:0]               op,
    output logic [2:0]               funct3,
    output logic                     funct7,
    input  logic                     redirect_valid,
    input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
    input  logic                     halt,
    output logic                     halted,
    output logic                     misalign_err
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    // Outstanding counters get headroom for stale requests that pile up behind redirects.
    localparam int unsigned OUT_W = PTR_W + 4;
    localparam logic [OUT_W-1:0] DEPTH_O = OUT_W'(FIFO_DEPTH);

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_HALTING = 2'd1;
    localparam logic [1:0] ST_HALTED  = 2'd2;

    logic [ADDRESS_WIDTH-1:0] pc_q, pc_d, shadow_pc_q, shadow_pc_d;
    logic [DATA_WIDTH-1:0]    data_mem_q [FIFO_DEPTH];
    logic [ADDRESS_WIDTH-1:0] pc_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic [OUT_W-1:0]         inflight_q, inflight_d, discard_q, discard_d;
    logic [OUT_W-1:0]         occupancy;
    logic [1:0]               state_q, state_d;
    logic                     misalign_q, misalign_d;
    logic                     req_fire, push, pop;
    logic [ADDRESS_WIDTH-1:0] redirect_aligned;

    assign redirect_aligned = {redirect_pc[ADDRESS_WIDTH-1:2], 2'b00};
    assign occupancy        = OUT_W'(count_q) + inflight_q - discard_q;

    // Held low while in reset so every output reads zero apart from the address.
    assign mem_req_valid = rst_n && (state_q == ST_RUN) && !redirect_valid && (occupancy < DEPTH_O);
    assign mem_addr      = pc_q;
    assign req_fire      = mem_req_valid && mem_req_ready;

    assign instr_valid = (count_q != '0);
    assign instr       = instr_valid ? data_mem_q[rd_ptr_q] : '0;
    assign instr_pc    = instr_valid ? pc_mem_q[rd_ptr_q] : '0;
    assign op          = instr[6:0];
    assign funct3      = instr[14:12];
    assign funct7      = instr[30];
    assign halted      = (state_q == ST_HALTED);
    assign misalign_err = misalign_q;

    assign push = mem_rsp_valid && (discard_q == '0) && !redirect_valid;
    assign pop  = instr_valid && instr_ready;

    always_comb begin
        pc_d        = pc_q;
        shadow_pc_d = shadow_pc_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
        inflight_d  = inflight_q + OUT_W'(req_fire) - OUT_W'(mem_rsp_valid);
        discard_d   = discard_q;
        misalign_d  = misalign_q;
        if (mem_rsp_valid && (discard_q != '0)) begin
            discard_d = discard_q - OUT_W'(1);
        end
        if (req_fire) begin
            pc_d = pc_q + ADDRESS_WIDTH'(4);
        end
        if (push) begin
            wr_ptr_d    = wr_ptr_q + PTR_W'(1);
            shadow_pc_d = shadow_pc_q + ADDRESS_WIDTH'(4);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        // A redirect wins: everything still in flight becomes stale, including later responses.
        if (redirect_valid) begin
            pc_d        = redirect_aligned;
            shadow_pc_d = redirect_aligned;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            discard_d   = inflight_d;
            misalign_d  = misalign_q || (redirect_pc[1:0] != 2'b00);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:     if (halt) state_d = ST_HALTING;
            ST_HALTING: begin
                if (!halt) state_d = ST_RUN;
                else if (inflight_q == '0) state_d = ST_HALTED;
            end
            ST_HALTED:  if (!halt) state_d = ST_RUN;
            default:    state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC;
            shadow_pc_q <= RESET_PC;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            inflight_q  <= '0;
            discard_q   <= '0;
            state_q     <= ST_RUN;
            misalign_q  <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            shadow_pc_q <= shadow_pc_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            inflight_q  <= inflight_d;
            discard_q   <= discard_d;
            state_q     <= state_d;
            misalign_q  <= misalign_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_mem_q[wr_ptr_q] <= mem_rsp_data;
            pc_mem_q[wr_ptr_q]   <= shadow_pc_q;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit: a transaction-level model (queues of pending
// requests and buffered PCs) predicts every output each cycle.
module tb_instr_fetch_unit;

    localparam int DEPTH = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_req_valid, mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        instr_valid, instr_ready;
    logic [31:0] instr, instr_pc;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt, halted, misalign_err;

    instr_fetch_unit #(
        .ADDRESS_WIDTH(32), .DATA_WIDTH(32), .FIFO_DEPTH(DEPTH), .RESET_PC(RST_PC)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
        .op(op), .funct3(funct3), .funct7(funct7),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halt(halt), .halted(halted), .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] addr;
        bit          stale;
    } pend_t;

    // Memory-side requests not yet answered, and PCs the decoder has yet to see.
    pend_t       pending[$];
    logic [31:0] bufPc[$];
    logic [31:0] modelPc;
    int          modelState;
    bit          modelMisalign;
    bit          haltIn;
    int          cycle = 0;
    int          latMin = 1, latMax = 1, readyPct = 100, instrReadyPct = 100;
    int          checks = 0, errors = 0;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h (cycle %0d)", tag, observed, expected, cycle);
        end
    endtask

    task automatic clearModel();
        bufPc.delete();
        pending.delete();
        modelPc = RST_PC;
        modelState = 0;
        modelMisalign = 0;
        haltIn = 0;
    endtask

    task automatic applyReset();
        rst_n = 1'b0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data = '0;
        instr_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        halt = 1'b0;
        clearModel();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_mem_req_valid", mem_req_valid, 0);
        checkOutput("rst_mem_addr", mem_addr, RST_PC);
        checkOutput("rst_instr_valid", instr_valid, 0);
        checkOutput("rst_instr", instr, 0);
        checkOutput("rst_instr_pc", instr_pc, 0);
        checkOutput("rst_op", op, 0);
        checkOutput("rst_funct3", funct3, 0);
        checkOutput("rst_funct7", funct7, 0);
        checkOutput("rst_halted", halted, 0);
        checkOutput("rst_misalign", misalign_err, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // One clock cycle: drive inputs, compare outputs to the model, then advance the model.
    task automatic applyStimulus(input bit doRedirect, input logic [31:0] rpc);
        bit          rspNow, expReq, pop;
        int          nonStale, inflightNow;
        logic [31:0] head, w;
        pend_t       p;

        rspNow = (pending.size() > 0) && (pending[0].due <= cycle);
        mem_rsp_valid = rspNow;
        mem_rsp_data = rspNow ? memWord(pending[0].addr) : $urandom;
        mem_req_ready = ($urandom_range(99) < readyPct);
        instr_ready = ($urandom_range(99) < instrReadyPct);
        redirect_valid = doRedirect;
        redirect_pc = rpc;
        halt = haltIn;

        @(negedge clk);
        nonStale = 0;
        foreach (pending[i]) if (!pending[i].stale) nonStale++;
        expReq = (modelState == 0) && !doRedirect && (bufPc.size() + nonStale < DEPTH);
        checkOutput("mem_req_valid", mem_req_valid, expReq);
        checkOutput("mem_addr", mem_addr, modelPc);
        checkOutput("instr_valid", instr_valid, bufPc.size() > 0);
        if (bufPc.size() > 0) begin
            head = bufPc[0];
            w = memWord(head);
            checkOutput("instr_pc", instr_pc, head);
            checkOutput("instr", instr, w);
            checkOutput("op", op, w[6:0]);
            checkOutput("funct3", funct3, w[14:12]);
            checkOutput("funct7", funct7, w[30]);
        end else begin
            checkOutput("instr_idle", instr, 0);
            checkOutput("instr_pc_idle", instr_pc, 0);
        end
        checkOutput("halted", halted, modelState == 2);
        checkOutput("misalign_err", misalign_err, modelMisalign);

        inflightNow = pending.size();
        pop = (bufPc.size() > 0) && instr_ready;
        if (pop) void'(bufPc.pop_front());
        if (rspNow) begin
            p = pending.pop_front();
            if (!p.stale && !doRedirect) bufPc.push_back(p.addr);
        end
        if (doRedirect) begin
            bufPc.delete();
            foreach (pending[i]) pending[i].stale = 1;
            modelPc = {rpc[31:2], 2'b00};
            if (rpc[1:0] != 2'b00) modelMisalign = 1;
        end else if (expReq && mem_req_ready) begin
            p.due = cycle + $urandom_range(latMax, latMin);
            p.addr = modelPc;
            p.stale = 0;
            pending.push_back(p);
            modelPc = modelPc + 32'd4;
        end
        case (modelState)
            0: if (haltIn) modelState = 1;
            1: if (!haltIn) modelState = 0; else if (inflightNow == 0) modelState = 2;
            default: if (!haltIn) modelState = 0;
        endcase

        @(posedge clk);
        #1;
        cycle++;
    endtask

    initial begin
        bit found;
        applyReset();

        $display("[TB] streaming with ready memory");
        repeat (20) applyStimulus(0, 0);

        $display("[TB] decoder stall then drain");
        instrReadyPct = 0;
        repeat (10) applyStimulus(0, 0);
        checkOutput("stall_buffered", bufPc.size(), DEPTH);
        checkOutput("stall_req_low", mem_req_valid, 0);
        instrReadyPct = 100;
        repeat (12) applyStimulus(0, 0);

        $display("[TB] redirect with requests in flight");
        latMin = 3; latMax = 3;
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (pending.size() >= 3) found = 1;
            else applyStimulus(0, 0);
        end
        checkOutput("wait_inflight", found, 1);
        applyStimulus(1, 32'h100);
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (instr_valid === 1'b1) found = 1;
            else applyStimulus(0, 0);
        end
        checkOutput("wait_after_redirect", found, 1);
        checkOutput("first_after_redirect", instr_pc, 32'h100);
        repeat (10) applyStimulus(0, 0);

        $display("[TB] redirect colliding with response and pop");
        latMin = 1; latMax = 1;
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (bufPc.size() > 0 && pending.size() > 0 && pending[0].due <= cycle) found = 1;
            else applyStimulus(0, 0);
        end
        checkOutput("wait_collision", found, 1);
        applyStimulus(1, 32'h200);
        checkOutput("collision_empty", instr_valid, 0);
        checkOutput("collision_addr", mem_addr, 32'h200);
        repeat (10) applyStimulus(0, 0);

        $display("[TB] misaligned redirect");
        applyStimulus(1, 32'h102);
        checkOutput("misalign_set", misalign_err, 1);
        checkOutput("misalign_addr", mem_addr, 32'h100);
        repeat (8) applyStimulus(0, 0);

        $display("[TB] halt with requests outstanding");
        latMin = 3; latMax = 3;
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (pending.size() == 2) found = 1;
            else applyStimulus(0, 0);
        end
        checkOutput("wait_two_inflight", found, 1);
        haltIn = 1;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (modelState == 2) found = 1;
            else applyStimulus(0, 0);
        end
        checkOutput("halt_reached", halted, 1);
        repeat (4) applyStimulus(0, 0);
        haltIn = 0;
        repeat (12) applyStimulus(0, 0);

        $display("[TB] randomized traffic");
        latMin = 1; latMax = 5; readyPct = 70; instrReadyPct = 60;
        for (int i = 0; i < 800; i++) begin
            if (i % 150 == 100) haltIn = 1;
            if (i % 150 == 130) haltIn = 0;
            if ($urandom_range(99) < 4)
                applyStimulus(1, $urandom & 32'h0000_0FFF);
            else
                applyStimulus(0, 0);
        end
        haltIn = 0;
        repeat (10) applyStimulus(0, 0);

        $display("[TB] reset in the middle of traffic");
        applyReset();
        latMin = 1; latMax = 2; readyPct = 100; instrReadyPct = 100;
        repeat (20) applyStimulus(0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
